dw_multifunc_sched: RTL and testbench

Round-robin scheduler that shares one DW_lp_multifunc instance among NUM_REQ requesters. It accepts operand/function requests over valid/ready and checks the function code. It issues one operation at a time to the shared unit and holds the operands stable for MF_LATENCY cycles. It then returns the result with the requester ID over a backpressured response channel. It sits between client datapaths and the shared multifunc unit, which is instantiated outside this block.

---
 rtl/dw_multifunc_sched_pkg.sv | 34 +++
 rtl/dw_multifunc_rr_arb.sv | 45 ++++
 rtl/dw_multifunc_sched.sv | 194 +++++++++++++++++++
 tb/tb_dw_multifunc_sched.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dw_multifunc_sched_pkg.sv
// Shared definitions for the dw_multifunc_sched scheduler slice.
// Contents:
//   state_e        - scheduler FSM states (IDLE, EXEC, RESP)
//   FUNC_W         - width of the one-hot multifunc function select
//   FUNC_B0..B6    - one-hot function-select constants for bits 0..6
//   is_legal_func  - true when a select is one-hot and implemented by the unit
package dw_multifunc_sched_pkg;

   localparam int FUNC_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam logic [FUNC_W-1:0] FUNC_B0 = 16'h0001;
   localparam logic [FUNC_W-1:0] FUNC_B1 = 16'h0002;
   localparam logic [FUNC_W-1:0] FUNC_B2 = 16'h0004;
   localparam logic [FUNC_W-1:0] FUNC_B3 = 16'h0008;
   localparam logic [FUNC_W-1:0] FUNC_B4 = 16'h0010;
   localparam logic [FUNC_W-1:0] FUNC_B5 = 16'h0020;
   localparam logic [FUNC_W-1:0] FUNC_B6 = 16'h0040;

   // A select is legal when exactly one bit is set and that bit is one the
   // shared unit was built with.
   function automatic logic is_legal_func(input logic [FUNC_W-1:0] func,
                                          input logic [FUNC_W-1:0] mask);
      logic one_hot;
      one_hot = (func != 16'h0000) && ((func & (func - 16'h0001)) == 16'h0000);
      return one_hot && ((func & mask) != 16'h0000);
   endfunction

endpackage

// File: rtl/dw_multifunc_rr_arb.sv
// Combinational round-robin arbiter.
// Ports:
//   req     - request vector, one bit per requester
//   ptr     - index with highest priority this cycle (must be < NUM_REQ)
//   en      - when low no grant is produced
//   gnt     - one-hot grant (all zero when nothing granted)
//   gnt_idx - binary index of the granted requester (0 when none)
module dw_multifunc_rr_arb #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   input  logic               en,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   gnt_idx
);

   localparam logic [IDX_W:0] N_EXT = (IDX_W+1)'(NUM_REQ);

   // Search upward from ptr with wrap; the first asserted request wins.
   always_comb begin
      logic           found;
      logic [IDX_W:0] sum_v;
      logic [IDX_W:0] cand_v;
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      sum_v   = '0;
      cand_v  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         // ptr < NUM_REQ and k < NUM_REQ, so one subtraction is enough to wrap
         sum_v  = {1'b0, ptr} + (IDX_W+1)'(k);
         cand_v = (sum_v >= N_EXT) ? (sum_v - N_EXT) : sum_v;
         if (en && !found && req[cand_v[IDX_W-1:0]]) begin
            gnt[cand_v[IDX_W-1:0]] = 1'b1;
            gnt_idx                = cand_v[IDX_W-1:0];
            found                  = 1'b1;
         end else begin
            found = found;
         end
      end
   end

endmodule

// File: rtl/dw_multifunc_sched.sv
// Round-robin scheduler sharing one external multifunc unit among NUM_REQ
// requesters. One operation is in flight at a time: a request is granted in
// IDLE, its operands are driven to the unit for MF_LATENCY cycles in EXEC,
// and the result is held in RESP until the consumer accepts it. Requests with
// an illegal function select skip the unit and answer with rsp_err.
// Ports:
//   clk, rst                    - clock, synchronous active-high reset
//   req_valid/req_ready         - per-requester handshake (ready one-hot or 0)
//   req_a, req_func             - packed operands / one-hot function selects
//   rsp_valid/rsp_ready         - response handshake
//   rsp_id, rsp_z, rsp_status,
//   rsp_err                     - response payload
//   mf_a, mf_func               - registered operands to the shared unit
//   mf_z, mf_status             - results from the shared unit
//   busy                        - scheduler is not idle
module dw_multifunc_sched
   import dw_multifunc_sched_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int OP_WIDTH    = 24,
   parameter int FUNC_SELECT = 127,
   parameter int MF_LATENCY  = 1,
   parameter int ID_W        = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ*(OP_WIDTH+1)-1:0] req_a,
   input  logic [NUM_REQ*FUNC_W-1:0]     req_func,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic [ID_W-1:0]               rsp_id,
   output logic [OP_WIDTH+1:0]           rsp_z,
   output logic                          rsp_status,
   output logic                          rsp_err,
   output logic [OP_WIDTH:0]             mf_a,
   output logic [FUNC_W-1:0]             mf_func,
   input  logic [OP_WIDTH+1:0]           mf_z,
   input  logic                          mf_status,
   output logic                          busy
);

   localparam int AW    = OP_WIDTH + 1;
   localparam int ZW    = OP_WIDTH + 2;
   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = (MF_LATENCY > 1) ? $clog2(MF_LATENCY) : 1;
   localparam logic [FUNC_W-1:0] FUNC_MASK = FUNC_W'(FUNC_SELECT);
   localparam logic [CNT_W-1:0]  CNT_INIT  = CNT_W'(MF_LATENCY - 1);
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_REQ - 1);

   state_e              state_q, state_d;
   logic [IDX_W-1:0]    ptr_q, ptr_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [AW-1:0]       mf_a_q, mf_a_d;
   logic [FUNC_W-1:0]   mf_func_q, mf_func_d;
   logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
   logic [ZW-1:0]       rsp_z_q, rsp_z_d;
   logic                rsp_status_q, rsp_status_d;
   logic                rsp_err_q, rsp_err_d;
   logic                rsp_valid_q, rsp_valid_d;

   logic [NUM_REQ-1:0]  gnt_s;
   logic [IDX_W-1:0]    gnt_idx_s;
   logic                arb_en_s;
   logic [AW-1:0]       sel_a_s;
   logic [FUNC_W-1:0]   sel_func_s;

   // Grants are only offered while idle and never during reset.
   assign arb_en_s = (state_q == IDLE) && !rst;

   dw_multifunc_rr_arb #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_arb (
      .req     (req_valid),
      .ptr     (ptr_q),
      .en      (arb_en_s),
      .gnt     (gnt_s),
      .gnt_idx (gnt_idx_s)
   );

   // One-hot AND-OR select of the granted requester's operands.
   always_comb begin
      sel_a_s    = '0;
      sel_func_s = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt_s[i]) begin
            sel_a_s    = sel_a_s    | req_a[i*AW +: AW];
            sel_func_s = sel_func_s | req_func[i*FUNC_W +: FUNC_W];
         end else begin
            sel_a_s    = sel_a_s;
         end
      end
   end

   // FSM next-state and datapath next-values.
   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      cnt_d        = cnt_q;
      mf_a_d       = mf_a_q;
      mf_func_d    = mf_func_q;
      rsp_id_d     = rsp_id_q;
      rsp_z_d      = rsp_z_q;
      rsp_status_d = rsp_status_q;
      rsp_err_d    = rsp_err_q;
      rsp_valid_d  = rsp_valid_q;
      case (state_q)
         IDLE: begin
            if (gnt_s != '0) begin
               ptr_d    = (gnt_idx_s == LAST_IDX) ? '0 : (gnt_idx_s + 1'b1);
               rsp_id_d = ID_W'(gnt_idx_s);
               if (is_legal_func(sel_func_s, FUNC_MASK)) begin
                  mf_a_d    = sel_a_s;
                  mf_func_d = sel_func_s;
                  cnt_d     = CNT_INIT;
                  state_d   = EXEC;
               end else begin
                  // Illegal select: answer directly, unit inputs untouched
                  rsp_err_d    = 1'b1;
                  rsp_z_d      = '0;
                  rsp_status_d = 1'b1;
                  rsp_valid_d  = 1'b1;
                  state_d      = RESP;
               end
            end else begin
               state_d = IDLE;
            end
         end
         EXEC: begin
            if (cnt_q == '0) begin
               rsp_z_d      = mf_z;
               rsp_status_d = mf_status;
               rsp_err_d    = 1'b0;
               rsp_valid_d  = 1'b1;
               state_d      = RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RESP: begin
            if (rsp_valid_q && rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end else begin
               state_d = RESP;
            end
         end
         default: begin
            rsp_valid_d = 1'b0;
            state_d     = IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         ptr_q        <= '0;
         cnt_q        <= '0;
         mf_a_q       <= '0;
         mf_func_q    <= '0;
         rsp_id_q     <= '0;
         rsp_z_q      <= '0;
         rsp_status_q <= 1'b0;
         rsp_err_q    <= 1'b0;
         rsp_valid_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         cnt_q        <= cnt_d;
         mf_a_q       <= mf_a_d;
         mf_func_q    <= mf_func_d;
         rsp_id_q     <= rsp_id_d;
         rsp_z_q      <= rsp_z_d;
         rsp_status_q <= rsp_status_d;
         rsp_err_q    <= rsp_err_d;
         rsp_valid_q  <= rsp_valid_d;
      end
   end

   assign req_ready  = gnt_s;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_id     = rsp_id_q;
   assign rsp_z      = rsp_z_q;
   assign rsp_status = rsp_status_q;
   assign rsp_err    = rsp_err_q;
   assign mf_a       = mf_a_q;
   assign mf_func    = mf_func_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_dw_multifunc_sched.sv
// Self-checking bench for dw_multifunc_sched (NUM_REQ=4, MF_LATENCY=2).
// A stand-in multifunc unit computes z/status from mf_a/mf_func; the
// reference model tracks the round-robin pointer and the last issued
// operands at transaction level and predicts every response.
module tb_dw_multifunc_sched;

   localparam int NR  = 4;
   localparam int OPW = 24;
   localparam int LAT = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic [NR-1:0]    req_valid;
   logic [NR-1:0]    req_ready;
   logic [NR*25-1:0] req_a;
   logic [NR*16-1:0] req_func;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [1:0]       rsp_id;
   logic [25:0]      rsp_z;
   logic             rsp_status;
   logic             rsp_err;
   logic [24:0]      mf_a;
   logic [15:0]      mf_func;
   logic [25:0]      mf_z;
   logic             mf_status;
   logic             busy;

   logic [24:0] a_arr [NR];
   logic [15:0] f_arr [NR];

   int          checks = 0;
   int          errors = 0;
   int          ptr_m;
   logic [24:0] last_a;
   logic [15:0] last_f;

   dw_multifunc_sched #(
      .NUM_REQ     (NR),
      .OP_WIDTH    (OPW),
      .FUNC_SELECT (127),
      .MF_LATENCY  (LAT),
      .ID_W        (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_func   (req_func),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_z      (rsp_z),
      .rsp_status (rsp_status),
      .rsp_err    (rsp_err),
      .mf_a       (mf_a),
      .mf_func    (mf_func),
      .mf_z       (mf_z),
      .mf_status  (mf_status),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Pack per-requester operands onto the flat buses.
   always_comb begin
      req_a    = '0;
      req_func = '0;
      for (int i = 0; i < NR; i++) begin
         req_a[i*25 +: 25]    = a_arr[i];
         req_func[i*16 +: 16] = f_arr[i];
      end
   end

   // Stand-in for the shared multifunc unit.
   function automatic logic [25:0] unit_z(input logic [24:0] a, input logic [15:0] f);
      return {1'b0, a} ^ {f, 10'h000};
   endfunction
   assign mf_z      = unit_z(mf_a, mf_func);
   assign mf_status = ^mf_a;

   function automatic int pick(input logic [NR-1:0] v, input int p);
      for (int k = 0; k < NR; k++) begin
         if (v[(p + k) % NR]) return (p + k) % NR;
      end
      return -1;
   endfunction

   function automatic bit legal_m(input logic [15:0] f);
      return ($countones(f) == 1) && ((f & 16'd127) != 16'd0);
   endfunction

   function automatic logic [15:0] rand_func();
      int sel;
      sel = $urandom_range(9, 0);
      if (sel < 7)       return 16'h0001 << sel;
      else if (sel == 7) return 16'h0080;
      else if (sel == 8) return 16'h0003;
      else               return 16'($urandom);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset();
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_z", rsp_z, 0);
      chk("rst_rsp_status", rsp_status, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_mf_a", mf_a, 0);
      chk("rst_mf_func", mf_func, 0);
      chk("rst_busy", busy, 0);
   endtask

   // One transaction from an idle cycle through the response handshake.
   // keep=1: the granted requester immediately posts a new operand.
   task automatic run_op(input int stall, input bit keep);
      int          g;
      logic [24:0] ea;
      logic [15:0] ef;
      bit          lg;
      #1;
      g = pick(req_valid, ptr_m);
      chk("idle_busy", busy, 0);
      chk("idle_rsp_valid", rsp_valid, 0);
      chk("idle_mf_a", mf_a, last_a);
      chk("idle_mf_func", mf_func, last_f);
      chk("grant", req_ready, (g < 0) ? 0 : (1 << g));
      if (g < 0) begin
         step();
         return;
      end
      ea    = a_arr[g];
      ef    = f_arr[g];
      lg    = legal_m(ef);
      ptr_m = (g + 1) % NR;
      step();
      if (keep) a_arr[g] = 25'($urandom);
      else      req_valid[g] = 1'b0;
      if (lg) begin
         last_a = ea;
         last_f = ef;
         for (int c = 0; c < LAT; c++) begin
            chk("exec_mf_a", mf_a, ea);
            chk("exec_mf_func", mf_func, ef);
            chk("exec_rsp_valid", rsp_valid, 0);
            chk("exec_req_ready", req_ready, 0);
            chk("exec_busy", busy, 1);
            step();
         end
      end
      for (int s = 0; s <= stall; s++) begin
         rsp_ready = (s == stall);
         #1;
         chk("rsp_valid", rsp_valid, 1);
         chk("rsp_id", rsp_id, g);
         chk("rsp_z", rsp_z, lg ? unit_z(ea, ef) : 26'h0);
         chk("rsp_status", rsp_status, lg ? ^ea : 1'b1);
         chk("rsp_err", rsp_err, !lg);
         chk("rsp_req_ready", req_ready, 0);
         chk("rsp_mf_a", mf_a, last_a);
         chk("rsp_mf_func", mf_func, last_f);
         step();
      end
      rsp_ready = 1'($urandom_range(1, 0));
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = '0;
      rsp_ready = 1'b0;
      for (int i = 0; i < NR; i++) begin
         a_arr[i] = '0;
         f_arr[i] = '0;
      end
      ptr_m  = 0;
      last_a = '0;
      last_f = '0;
      step();
      step();
      chk_reset();
      rst = 1'b0;

      // All four requesting continuously: grants 0,1,2,3,0
      for (int i = 0; i < NR; i++) begin
         a_arr[i] = 25'($urandom);
         f_arr[i] = 16'h0001 << i;
      end
      req_valid = 4'b1111;
      for (int n = 0; n < 5; n++) run_op(0, 1'b1);

      // Requester 1 alone with the reference operand
      req_valid = 4'b0000;
      a_arr[1]  = 25'h0400000;
      f_arr[1]  = 16'h0002;
      req_valid = 4'b0010;
      run_op(0, 1'b0);

      // Illegal selects: two bits set, then a bit outside the mask
      f_arr[2]  = 16'h0003;
      req_valid = 4'b0100;
      run_op(0, 1'b0);
      f_arr[3]  = 16'h0080;
      req_valid = 4'b1000;
      run_op(0, 1'b0);

      // Long backpressure with all requesters pending
      for (int i = 0; i < NR; i++) f_arr[i] = 16'h0004;
      req_valid = 4'b1111;
      run_op(10, 1'b1);
      run_op(0, 1'b1);

      // Reset in the middle of EXEC
      req_valid = 4'b0000;
      step();
      a_arr[3]  = 25'($urandom);
      f_arr[3]  = 16'h0010;
      req_valid = 4'b1000;
      #1;
      chk("mid_grant", req_ready, 4'b1000 >> ((ptr_m == 3) ? 0 : 0));
      step();
      req_valid = 4'b1111;
      chk("mid_busy", busy, 1);
      rst = 1'b1;
      step();
      chk_reset();
      rst    = 1'b0;
      ptr_m  = 0;
      last_a = '0;
      last_f = '0;
      run_op(0, 1'b1);

      // Pointer wrap: move pointer to 3, then 0101 grants 0 and pointer -> 1
      req_valid = 4'b0000;
      f_arr[2]  = 16'h0040;
      req_valid = 4'b0100;
      run_op(0, 1'b0);
      req_valid = 4'b0101;
      run_op(0, 1'b0);
      req_valid = 4'b1111;
      run_op(0, 1'b1);

      // Randomized traffic against the model
      for (int n = 0; n < 40; n++) begin
         for (int i = 0; i < NR; i++) begin
            a_arr[i] = 25'($urandom);
            f_arr[i] = rand_func();
         end
         req_valid = 4'($urandom_range(15, 0));
         run_op($urandom_range(3, 0), 1'($urandom_range(1, 0)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
